// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with operand forwarding and load-use hazard stall; FORWARDING_EN selects forwarding vs. stall-on-any-pending-write.
// Latency: one cycle ID->EX; forwarding muxes are combinational on the registered source indices.
// Backpressure: id_stall holds IF/ID and injects a bubble into EX; flush overrides stall and kills the entering instruction.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rd1,
    input  logic [31:0] id_rd2,
    input  logic [31:0] id_imm,
    input  logic [3:0]  id_alu_sel,
    input  logic        id_src_b,
    input  logic        id_mem_read,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_result,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_result,
    output logic        id_stall,
    output logic        ex_valid,
    output logic [31:0] ex_d0,
    output logic [31:0] ex_d1,
    output logic [3:0]  ex_s,
    output logic [4:0]  ex_rd,
    output logic        ex_mem_read,
    output logic [31:0] ex_store_data
);

    logic        valid_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [4:0]  rd_q;
    logic [31:0] rd1_q;
    logic [31:0] rd2_q;
    logic [31:0] imm_q;
    logic [3:0]  alu_sel_q;
    logic        src_b_q;
    logic        mem_read_q;

    logic        stall;
    logic [31:0] op_a;
    logic [31:0] op_b;

    // Bubble on flush or stall; the remaining fields simply hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rd_q       <= 5'd0;
            rd1_q      <= 32'd0;
            rd2_q      <= 32'd0;
            imm_q      <= 32'd0;
            alu_sel_q  <= 4'd0;
            src_b_q    <= 1'b0;
            mem_read_q <= 1'b0;
        end else if (flush || stall) begin
            valid_q    <= 1'b0;
        end else begin
            valid_q    <= id_valid;
            rs1_q      <= id_rs1;
            rs2_q      <= id_rs2;
            rd_q       <= id_rd;
            rd1_q      <= id_rd1;
            rd2_q      <= id_rd2;
            imm_q      <= id_imm;
            alu_sel_q  <= id_alu_sel;
            src_b_q    <= id_src_b;
            mem_read_q <= id_mem_read;
        end
    end

`ifdef FORWARDING_EN
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  rs,
        input logic [31:0] rf_dat,
        input logic [4:0]  m_rd,
        input logic [31:0] m_dat,
        input logic [4:0]  w_rd,
        input logic [31:0] w_dat
    );
        if (rs != 5'd0 && rs == m_rd)
            return m_dat;
        else if (rs != 5'd0 && rs == w_rd)
            return w_dat;
        else
            return rf_dat;
    endfunction

    always_comb begin
        op_a = fwd_sel(rs1_q, rd1_q, mem_rd, mem_result, wb_rd, wb_result);
        op_b = fwd_sel(rs2_q, rd2_q, mem_rd, mem_result, wb_rd, wb_result);
    end

    // Only a load in EX cannot be forwarded in time; depends on registered state and ID only.
    always_comb begin
        stall = 1'b0;
        if (!flush && id_valid && valid_q && mem_read_q && rd_q != 5'd0 &&
            (rd_q == id_rs1 || rd_q == id_rs2))
            stall = 1'b1;
    end
`else
    function automatic logic pending_hit(
        input logic [4:0] rs,
        input logic       ex_vld,
        input logic [4:0] e_rd,
        input logic [4:0] m_rd,
        input logic [4:0] w_rd
    );
        return (rs != 5'd0) && ((ex_vld && rs == e_rd) || rs == m_rd || rs == w_rd);
    endfunction

    always_comb begin
        op_a = rd1_q;
        op_b = rd2_q;
    end

    // Without bypass paths, any in-flight writer of a source register must drain first.
    always_comb begin
        stall = 1'b0;
        if (!flush && id_valid &&
            (pending_hit(id_rs1, valid_q, rd_q, mem_rd, wb_rd) ||
             pending_hit(id_rs2, valid_q, rd_q, mem_rd, wb_rd)))
            stall = 1'b1;
    end
`endif

    assign id_stall      = stall;
    assign ex_valid      = valid_q;
    assign ex_d0         = op_a;
    assign ex_d1         = src_b_q ? imm_q : op_b;
    assign ex_s          = alu_sel_q;
    assign ex_rd         = valid_q ? rd_q : 5'd0;
    assign ex_mem_read   = valid_q & mem_read_q;
    assign ex_store_data = op_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/forwarding cases plus randomized traffic against a scoreboard model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic [3:0]  id_alu_sel;
    logic        id_src_b, id_mem_read;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_result, wb_result;
    logic        id_stall, ex_valid, ex_mem_read;
    logic [31:0] ex_d0, ex_d1, ex_store_data;
    logic [3:0]  ex_s;
    logic [4:0]  ex_rd;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_alu_sel(id_alu_sel), .id_src_b(id_src_b), .id_mem_read(id_mem_read),
        .mem_rd(mem_rd), .mem_result(mem_result), .wb_rd(wb_rd), .wb_result(wb_result),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_d0(ex_d0), .ex_d1(ex_d1),
        .ex_s(ex_s), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_store_data(ex_store_data)
    );

    typedef struct {
        logic        vld;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm;
        logic [3:0]  sel;
        logic        srcb, mr;
    } ex_model_t;

    ex_model_t m;
    ex_model_t sb_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rfv);
`ifdef FORWARDING_EN
        if (rs != 0 && rs == mem_rd) return mem_result;
        if (rs != 0 && rs == wb_rd)  return wb_result;
`endif
        return rfv;
    endfunction

    function automatic logic hit(input logic [4:0] rs);
`ifdef FORWARDING_EN
        return m.vld && m.mr && m.rd != 0 && rs == m.rd;
`else
        return rs != 0 && ((m.vld && rs == m.rd) || rs == mem_rd || rs == wb_rd);
`endif
    endfunction

    function automatic logic model_stall();
        return !flush && id_valid && (hit(id_rs1) || hit(id_rs2));
    endfunction

    task automatic model_clear();
        m = '{vld: 1'b0, rs1: 0, rs2: 0, rd: 0, rd1: 0, rd2: 0, imm: 0, sel: 0, srcb: 1'b0, mr: 1'b0};
        sb_q.delete();
    endtask

    // One pipeline cycle: check stall for the driven inputs, predict EX, clock, compare.
    task automatic step();
        logic      st;
        ex_model_t e;
        #1;
        st = model_stall();
        check("id_stall", {31'd0, id_stall}, {31'd0, st});
        if (flush || st) begin
            m.vld = 1'b0;
        end else begin
            m = '{vld: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd, rd1: id_rd1, rd2: id_rd2,
                  imm: id_imm, sel: id_alu_sel, srcb: id_src_b, mr: id_mem_read};
        end
        sb_q.push_back(m);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("ex_valid", {31'd0, ex_valid}, {31'd0, e.vld});
            check("ex_rd", {27'd0, ex_rd}, e.vld ? {27'd0, e.rd} : 32'd0);
            check("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, e.vld & e.mr});
            if (e.vld) begin
                check("ex_s", {28'd0, ex_s}, {28'd0, e.sel});
                check("ex_d0", ex_d0, fwd(e.rs1, e.rd1));
                check("ex_d1", ex_d1, e.srcb ? e.imm : fwd(e.rs2, e.rd2));
                check("ex_store", ex_store_data, fwd(e.rs2, e.rd2));
            end
        end
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                            input logic [31:0] imm, input logic [3:0] sel, input logic srcb,
                            input logic mr);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rd1 = rd1; id_rd2 = rd2;
        id_imm = imm; id_alu_sel = sel; id_src_b = srcb; id_mem_read = mr;
    endtask

    task automatic drive_fwd(input logic [4:0] mr, input logic [31:0] md,
                             input logic [4:0] wr, input logic [31:0] wd);
        mem_rd = mr; mem_result = md; wb_rd = wr; wb_result = wd;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive_id(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        drive_fwd(0, 0, 0, 0);
        model_clear();
        #12;
        check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
        check("rst_ex_d0", ex_d0, 32'd0);
        check("rst_ex_d1", ex_d1, 32'd0);
        check("rst_ex_s", {28'd0, ex_s}, 32'd0);
        check("rst_stall", {31'd0, id_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // x0 source with immediate operand B
        drive_id(1'b1, 0, 0, 5'd1, 32'h10, 32'h1234, 32'hFFFF_FFFC, 4'h3, 1'b1, 1'b0);
        step();
        check("x0_imm_d1", ex_d1, 32'hFFFF_FFFC);
        check("x0_store", ex_store_data, 32'h1234);

`ifdef FORWARDING_EN
        drive_id(1'b1, 5'd5, 0, 5'd2, 32'h11, 32'h22, 0, 4'h1, 1'b0, 1'b0);
        drive_fwd(5'd5, 32'hAA, 5'd5, 32'hBB);
        step();
        check("mem_fwd_d0", ex_d0, 32'hAA);
        drive_fwd(0, 0, 0, 0);
        drive_id(1'b1, 0, 0, 5'd7, 0, 0, 32'h4, 4'h0, 1'b1, 1'b1);
        step();
        drive_id(1'b1, 5'd1, 5'd7, 5'd8, 32'h5, 32'h6, 0, 4'h2, 1'b0, 1'b0);
        #1;
        check("lu_stall", {31'd0, id_stall}, 32'd1);
        step();
        check("lu_bubble", {31'd0, ex_valid}, 32'd0);
        step();
        check("lu_capture", {27'd0, ex_rd}, 32'd8);
        drive_id(1'b1, 0, 0, 5'd7, 0, 0, 32'h4, 4'h0, 1'b1, 1'b1);
        step();
        drive_id(1'b1, 5'd7, 0, 5'd9, 0, 0, 0, 4'h2, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        check("flush_stall", {31'd0, id_stall}, 32'd0);
        step();
        check("flush_bubble", {31'd0, ex_valid}, 32'd0);
        flush = 1'b0;
`else
        drive_id(1'b1, 5'd3, 0, 5'd4, 32'h33, 0, 0, 4'h1, 1'b0, 1'b0);
        drive_fwd(0, 0, 5'd3, 32'hBB);
        #1;
        check("wb_stall", {31'd0, id_stall}, 32'd1);
        step();
        step();
        check("wb_stall_hold", {31'd0, id_stall}, 32'd1);
        drive_fwd(0, 0, 5'd6, 32'hBB);
        #1;
        check("wb_release", {31'd0, id_stall}, 32'd0);
        step();
        check("wb_capture_d0", ex_d0, 32'h33);
        drive_fwd(0, 0, 0, 0);
        drive_id(1'b1, 0, 0, 5'd7, 0, 0, 32'h4, 4'h0, 1'b1, 1'b1);
        step();
        drive_id(1'b1, 0, 5'd7, 5'd8, 0, 0, 0, 4'h2, 1'b0, 1'b0);
        #1;
        check("ex_pend_stall", {31'd0, id_stall}, 32'd1);
        flush = 1'b1;
        #1;
        check("flush_stall", {31'd0, id_stall}, 32'd0);
        step();
        check("flush_bubble", {31'd0, ex_valid}, 32'd0);
        flush = 1'b0;
`endif

        for (int i = 0; i < 400; i++) begin
            drive_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
            drive_fwd(5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom);
            flush = ($urandom_range(0, 7) == 0);
            step();
        end
        flush = 1'b0;

        // Mid-stream asynchronous reset, away from any clock edge
        drive_id(1'b1, 0, 0, 5'd3, 32'h77, 32'h88, 0, 4'h5, 1'b0, 1'b0);
        drive_fwd(0, 0, 0, 0);
        step();
        #2;
        drive_id(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("arst_ex_rd", {27'd0, ex_rd}, 32'd0);
        check("arst_ex_d0", ex_d0, 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_id(1'b1, 0, 0, 5'd2, 32'h99, 32'h1, 0, 4'h6, 1'b0, 1'b0);
        step();
        check("post_rst_d0", ex_d0, 32'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 flush  in  1  kill the instruction entering EX (taken branch/jump).
REQ-004 id_valid  in  1  decode stage holds a valid instruction.
REQ-005 id_rs1  in  5  source register 1; 0 when unused or PC-relative (pc pre-muxed into id_rd1).
REQ-006 id_rs2  in  5  source register 2; 0 when unused.
REQ-007 id_rd  in  5  destination register; 0 = no write.
REQ-008 id_rd1  in  32  register-file read data 1 (or pc).
REQ-009 id_rd2  in  32  register-file read data 2.
REQ-010 id_imm  in  32  sign-extended immediate.
REQ-011 id_alu_sel  in  4  ALU operation code; passed through unchanged.
REQ-012 id_src_b  in  1  1 = operand B is id_imm, 0 = forwarded rs2 value.
REQ-013 id_mem_read  in  1  instruction is a load.
REQ-014 mem_rd  in  5  destination in MEM stage; 0 = no write.
REQ-015 mem_result  in  32  value MEM stage will write.
REQ-016 wb_rd  in  5  destination in WB stage; 0 = no write.
REQ-017 wb_result  in  32  value WB stage writes.
REQ-018 id_stall  out  1  hold IF/ID this cycle.
REQ-019 ex_valid  out  1  EX holds a valid instruction.
REQ-020 ex_d0  out  32  ALU operand A.
REQ-021 ex_d1  out  32  ALU operand B.
REQ-022 ex_s  out  4  ALU operation code.
REQ-023 ex_rd  out  5  EX destination; forced 0 when ex_valid=0.
REQ-024 ex_mem_read  out  1  EX is a load; forced 0 when ex_valid=0.
REQ-025 ex_store_data  out  32  forwarded rs2 value (store data), independent of id_src_b.

Function
REQ-026 Registered fields: valid, rs1, rs2, rd, rd1, rd2, imm, alu_sel, src_b, mem_read; one-cycle latency ID -> EX.
REQ-027 Per edge, priority flush > stall > load: flush -> valid<=0; else id_stall -> valid<=0 (bubble), other fields don't-care; else capture all ID fields, valid<=id_valid.
REQ-028 Load-use hazard: id_stall=1 when id_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2); id_stall=0 whenever flush=1.
REQ-029 Forwarding (combinational on registered rs): rsN!=0 & rsN==mem_rd -> mem_result; else rsN!=0 & rsN==wb_rd -> wb_result; else registered rdN; MEM has priority over WB; x0 never forwarded.
REQ-030 ex_d0 = forwarded rs1; ex_d1 = id_src_b ? imm : forwarded rs2 (registered src_b); ex_s = registered alu_sel.
REQ-031 Stall lasts exactly one cycle per load-use; sustained id_valid with same hazard re-evaluates each cycle.
REQ-032 No combinational path from mem_*/wb_* to id_stall.

Reset
REQ-033 rst_n low asynchronously clears all registers: ex_valid=0, ex_rd=0, ex_mem_read=0, ex_s=0, ex_d0/ex_d1/ex_store_data=0 (via cleared data/rs fields, mem_rd/wb_rd assumed 0).
REQ-034 Reset release: first capture on first rising edge with rst_n high; id_stall=0 during reset.

Configuration
REQ-035 FORWARDING_EN defined: REQ-028/REQ-029 as written.
REQ-036 FORWARDING_EN undefined: no forwarding (operands = registered rd1/rd2); id_stall=1 when id_valid and a nonzero id_rs1/id_rs2 matches ex_rd (ex_valid), mem_rd or wb_rd; flush still overrides.

Verification
REQ-037 Reset: rst_n=0 mid-stream -> ex_valid=0, ex_rd=0, ex_d0=0 immediately, without clock edge.
REQ-038 MEM forward: EX rs1=5, rd1=0x11, mem_rd=5, mem_result=0xAA, wb_rd=5, wb_result=0xBB -> ex_d0=0xAA.
REQ-039 Load-use: EX lw rd=7; ID add rs2=7 -> id_stall=1 one cycle, next cycle ex_valid=0, then add captured (with FORWARDING_EN).
REQ-040 Flush+stall: flush=1 during load-use hazard -> id_stall=0, next ex_valid=0.
REQ-041 x0/immediate: rs2=0, mem_rd=0, src_b=1, imm=0xFFFFFFFC -> ex_d1=0xFFFFFFFC, ex_store_data=registered rd2.
REQ-042 No FORWARDING_EN: ID rs1=3, wb_rd=3 -> id_stall=1 until wb_rd!=3.
